// File: rtl/stereo_pkg.sv
// stereo_pkg: constants and types shared by the SAD stage and the disparity selector
package stereo_pkg;
    localparam int STEREO_DATA_WIDTH = 8;
    localparam int STEREO_MAX_DISP = 64;
    localparam logic [STEREO_DATA_WIDTH-1:0] SAD_INVALID = '1;
    typedef enum logic {IDLE, ACCUM} wta_state_t;
endpackage

// File: rtl/disparity_wta.sv
// disparity_wta: winner-takes-all minimum-cost disparity selection over a per-pixel SAD cost stream
module disparity_wta
    import stereo_pkg::*;
#(
    parameter int DATA_WIDTH = STEREO_DATA_WIDTH,
    parameter int MAX_DISP = STEREO_MAX_DISP,
    localparam int DISP_WIDTH = (MAX_DISP > 1) ? $clog2(MAX_DISP) : 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] i_sad_data,
    input  logic                  i_sad_valid,
    input  logic                  i_first,
    output logic [DISP_WIDTH-1:0] o_disp_data,
    output logic [DATA_WIDTH-1:0] o_min_cost,
    output logic                  o_disp_invalid,
    output logic                  o_disp_valid,
    output logic                  o_seq_err
);
    localparam int CNT_WIDTH = DISP_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(MAX_DISP - 1);
    localparam logic [DATA_WIDTH-1:0] INVALID = '1;
    wta_state_t            r_state, w_state;
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt;
    logic [DATA_WIDTH-1:0] r_best_cost, w_cost;
    logic [DISP_WIDTH-1:0] r_best_idx, w_idx;
    logic                  w_load, w_step, w_take, w_done, w_seq_err;
    // Candidate accept, strict-less-than compare/select and next-state decode
    always_comb begin
        w_load    = ready & i_sad_valid & i_first;
        w_step    = ready & i_sad_valid & ~i_first & (r_state == ACCUM);
        w_take    = w_load | (w_step & (i_sad_data < r_best_cost));
        w_cost    = w_take ? i_sad_data : r_best_cost;
        w_idx     = w_load ? '0 : w_take ? r_cnt[DISP_WIDTH-1:0] : r_best_idx;
        w_done    = (w_load & (MAX_DISP == 1)) | (w_step & (r_cnt == LAST));
        w_cnt     = w_done ? '0 : w_load ? CNT_WIDTH'(1) : w_step ? r_cnt + 1'b1 : r_cnt;
        w_state   = w_done ? IDLE : w_load ? ACCUM : r_state;
        w_seq_err = o_seq_err | (ready & i_sad_valid & ((~i_first & (r_state == IDLE)) | (i_first & (r_state == ACCUM))));
    end
    // State, running best and output registers; everything holds while ready is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_best_cost    <= INVALID;
            r_best_idx     <= '0;
            o_disp_data    <= '0;
            o_min_cost     <= INVALID;
            o_disp_invalid <= 1'b0;
            o_disp_valid   <= 1'b0;
            o_seq_err      <= 1'b0;
        end else if (ready) begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_best_cost  <= w_cost;
            r_best_idx   <= w_idx;
            o_disp_valid <= w_done;
            o_seq_err    <= w_seq_err;
            if (w_done) begin
                o_disp_data    <= w_idx;
                o_min_cost     <= w_cost;
                o_disp_invalid <= (w_cost == INVALID);
            end
        end
    end
endmodule

// File: tb/tb_disparity_wta.sv
// tb_disparity_wta: directed and random scoreboard bench for disparity_wta with 4 candidates of 8 bits
module tb_disparity_wta;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] i_sad_data = '0;
    logic       i_sad_valid = 1'b0;
    logic       i_first = 1'b0;
    logic [1:0] o_disp_data;
    logic [7:0] o_min_cost;
    logic       o_disp_invalid, o_disp_valid, o_seq_err;

    typedef struct packed {
        logic [1:0] d;
        logic [7:0] c;
        logic       inv;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushed = 0;
    int   popped = 0;
    bit   last_en = 1'b0;

    disparity_wta #(.DATA_WIDTH(8), .MAX_DISP(4)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .i_sad_data(i_sad_data), .i_sad_valid(i_sad_valid), .i_first(i_first),
        .o_disp_data(o_disp_data), .o_min_cost(o_min_cost),
        .o_disp_invalid(o_disp_invalid), .o_disp_valid(o_disp_valid), .o_seq_err(o_seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // remember whether the last rising edge was an enabled one
    always @(posedge clk) last_en = ready & ~rst;

    // compare each fresh result against the oldest expected pixel
    always @(negedge clk) begin
        if (last_en && o_disp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(o_disp_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                popped++;
                chk("disp", 32'(o_disp_data), 32'(e.d));
                chk("cost", 32'(o_min_cost), 32'(e.c));
                chk("invalid", 32'(o_disp_invalid), 32'(e.inv));
            end
        end
    end

    // present one candidate, optionally held off by stall cycles, returning on the negedge after acceptance
    task automatic send(input logic [7:0] c, input logic f, input int stalls);
        logic [31:0] snap;
        i_sad_data = c;
        i_sad_valid = 1'b1;
        i_first = f;
        if (stalls > 0) begin
            ready = 1'b0;
            snap = 32'({o_disp_data, o_min_cost, o_disp_invalid, o_disp_valid, o_seq_err});
            repeat (stalls) begin
                @(posedge clk);
                @(negedge clk);
                chk("stall_hold", 32'({o_disp_data, o_min_cost, o_disp_invalid, o_disp_valid, o_seq_err}), snap);
            end
        end
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_sad_valid = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            ready = 1'($urandom_range(0, 1));
            i_sad_valid = 1'b0;
            i_first = 1'($urandom_range(0, 1));
            i_sad_data = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        ready = 1'b1;
    endtask

    task automatic flush(input int n);
        ready = 1'b1;
        i_sad_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pixel(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                         input logic [7:0] c3, input int stall_idx, input int stall_n);
        logic [7:0] c[4];
        exp_t e;
        c = '{c0, c1, c2, c3};
        e.d = 2'd0;
        e.c = c[0];
        for (int k = 1; k < 4; k++) begin
            if (c[k] < e.c) begin
                e.c = c[k];
                e.d = 2'(k);
            end
        end
        e.inv = (e.c == 8'hff);
        for (int k = 0; k < 4; k++) send(c[k], k == 0, k == stall_idx ? stall_n : 0);
        q.push_back(e);
        pushed++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_disp", 32'(o_disp_data), 32'd0);
        chk("rst_cost", 32'(o_min_cost), 32'hff);
        chk("rst_invalid", 32'(o_disp_invalid), 32'd0);
        chk("rst_valid", 32'(o_disp_valid), 32'd0);
        chk("rst_seq_err", 32'(o_seq_err), 32'd0);
        rst = 1'b0;
        ready = 1'b1;
        flush(1);

        pixel(8'd40, 8'd12, 8'd30, 8'd25, -1, 0);
        flush(3);
        pixel(8'd255, 8'd9, 8'd9, 8'd255, -1, 0);
        pixel(8'd255, 8'd255, 8'd255, 8'd255, -1, 0);
        flush(2);
        pixel(8'd5, 8'd3, 8'd7, 8'd1, -1, 0);
        pixel(8'd2, 8'd2, 8'd2, 8'd2, 2, 3);
        flush(2);
        chk("seq_err_clear", 32'(o_seq_err), 32'd0);

        send(8'd10, 1'b0, 0);
        chk("seq_err_drop", 32'(o_seq_err), 32'd1);
        send(8'd8, 1'b1, 0);
        send(8'd4, 1'b0, 0);
        pixel(8'd6, 8'd7, 8'd1, 8'd9, -1, 0);
        flush(2);
        chk("seq_err_sticky", 32'(o_seq_err), 32'd1);

        send(8'd50, 1'b1, 0);
        send(8'd60, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_disp", 32'(o_disp_data), 32'd0);
        chk("arst_cost", 32'(o_min_cost), 32'hff);
        chk("arst_invalid", 32'(o_disp_invalid), 32'd0);
        chk("arst_valid", 32'(o_disp_valid), 32'd0);
        chk("arst_seq_err", 32'(o_seq_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        flush(1);
        pixel(8'd20, 8'd10, 8'd0, 8'd30, -1, 0);
        flush(2);

        for (int p = 0; p < 1000; p++) begin
            logic [7:0] r[4];
            bit all_inv;
            all_inv = ($urandom_range(0, 9) == 0);
            for (int k = 0; k < 4; k++)
                r[k] = (all_inv || $urandom_range(0, 3) == 0) ? 8'hff : 8'($urandom_range(0, 20));
            if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
            pixel(r[0], r[1], r[2], r[3], $urandom_range(0, 5), $urandom_range(1, 2));
        end
        flush(4);
        chk("drain_empty", 32'(q.size()), 32'd0);
        chk("result_count", 32'(popped), 32'(pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
